// File: rtl/game_timer_pkg.sv
// game_timer_pkg
//   Shared definitions for the game timer: FSM state encodings, the default
//   prescaler divide ratio and the BCD digit clamp used on load.
package game_timer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      LOADED  = 2'b01,
      RUN     = 2'b10,
      EXPIRED = 2'b11
   } state_t;

   // CLK cycles per one-second tick on the production 50 MHz clock.
   localparam int TICK_DIV_DEFAULT = 50000000;

   // Saturate an out-of-range BCD digit (A..F) to 9.
   function automatic logic [3:0] clamp_digit(input logic [3:0] digit);
      logic [3:0] result;
      if (digit > 4'd9) begin
         result = 4'd9;
      end else begin
         result = digit;
      end
      return result;
   endfunction

endpackage

// File: rtl/game_timer_sec_prescaler.sv
// sec_prescaler
//   Divides CLK down to a one-second tick for the game timer.
//   Ports:
//     CLK      system clock
//     RST      asynchronous active-low reset
//     clear    synchronous clear of the divider (wins over count_en)
//     count_en advance the divider this cycle; holds its value when low
//     tick     high for the one cycle in which the divider wraps to 0
module sec_prescaler
   import game_timer_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
   input  logic CLK,
   input  logic RST,
   input  logic clear,
   input  logic count_en,
   output logic tick
);

   localparam int             CW   = $clog2(TICK_DIV);
   localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_r;

   // Divider counter: clear first, otherwise advance and wrap at LAST.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cnt_r <= '0;
      end else if (clear) begin
         cnt_r <= '0;
      end else if (count_en) begin
         if (cnt_r == LAST) begin
            cnt_r <= '0;
         end else begin
            cnt_r <= cnt_r + 1'b1;
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // The tick coincides with the wrap edge so the parent decrements on it.
   assign tick = count_en && !clear && (cnt_r == LAST);

endmodule

// File: rtl/game_timer.sv
// game_timer
//   Two-digit BCD countdown for a game session, driven by an access FSM.
//   Ports:
//     CLK       system clock
//     RST       asynchronous active-low reset
//     enable    count-down permission (play in progress)
//     reconf    reload request; loads time_in in any state
//     time_in   game duration, BCD [7:4] tens, [3:0] ones (digits > 9 clamp)
//     timeout   registered level, high once the count has expired
//     sec_tens  remaining seconds, tens digit
//     sec_ones  remaining seconds, ones digit
//     running   registered: state is RUN and enable was high
module game_timer
   import game_timer_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       enable,
   input  logic       reconf,
   input  logic [7:0] time_in,
   output logic       timeout,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       running
);

   state_t     state_r, state_s;
   logic [3:0] tens_r, tens_s;
   logic [3:0] ones_r, ones_s;
   logic       timeout_r, timeout_s;
   logic       running_r, running_s;
   logic       zero_s;
   logic       count_en_s;
   logic       tick_s;

   assign zero_s = (tens_r == 4'd0) && (ones_r == 4'd0);

   // The divider only runs in RUN with a non-zero count and no reload pending;
   // a reload clears it so every fresh count starts with a full second.
   assign count_en_s = (state_r == RUN) && enable && !reconf && !zero_s;

   sec_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .CLK      (CLK),
      .RST      (RST),
      .clear    (reconf),
      .count_en (count_en_s),
      .tick     (tick_s)
   );

   // Next-state, next-count and next-output decode.
   always_comb begin
      state_s   = state_r;
      tens_s    = tens_r;
      ones_s    = ones_r;
      timeout_s = timeout_r;
      if (reconf) begin
         // A reload wins over enable and over a coincident tick in every state.
         state_s   = LOADED;
         tens_s    = clamp_digit(time_in[7:4]);
         ones_s    = clamp_digit(time_in[3:0]);
         timeout_s = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               state_s = IDLE;
            end
            LOADED: begin
               if (enable) begin
                  state_s = RUN;
               end else begin
                  state_s = LOADED;
               end
            end
            RUN: begin
               if (zero_s) begin
                  // Started with nothing on the clock: expire without a tick.
                  state_s   = EXPIRED;
                  timeout_s = 1'b1;
               end else if (tick_s) begin
                  if (ones_r == 4'd0) begin
                     ones_s = 4'd9;
                     tens_s = tens_r - 4'd1;
                  end else begin
                     ones_s = ones_r - 4'd1;
                  end
                  if ((tens_r == 4'd0) && (ones_r == 4'd1)) begin
                     state_s   = EXPIRED;
                     timeout_s = 1'b1;
                  end else begin
                     state_s = RUN;
                  end
               end else begin
                  state_s = RUN;
               end
            end
            EXPIRED: begin
               state_s   = EXPIRED;
               tens_s    = 4'd0;
               ones_s    = 4'd0;
               timeout_s = 1'b1;
            end
            default: begin
               state_s   = IDLE;
               tens_s    = 4'd0;
               ones_s    = 4'd0;
               timeout_s = 1'b0;
            end
         endcase
      end
      running_s = (state_s == RUN) && enable;
   end

   // State, count and output registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r   <= IDLE;
         tens_r    <= 4'd0;
         ones_r    <= 4'd0;
         timeout_r <= 1'b0;
         running_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         tens_r    <= tens_s;
         ones_r    <= ones_s;
         timeout_r <= timeout_s;
         running_r <= running_s;
      end
   end

   assign timeout  = timeout_r;
   assign sec_tens = tens_r;
   assign sec_ones = ones_r;
   assign running  = running_r;

endmodule

// File: tb/tb_game_timer.sv
// tb_game_timer
//   Directed scoreboard bench for game_timer with TICK_DIV = 4.
module tb_game_timer;

   logic       CLK     = 1'b0;
   logic       RST     = 1'b0;
   logic       enable  = 1'b0;
   logic       reconf  = 1'b0;
   logic [7:0] time_in = 8'h00;
   logic       timeout;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       running;

   typedef struct {
      string      name;
      logic [3:0] tens;
      logic [3:0] ones;
      logic       to;
      logic       run;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;

   game_timer #(
      .TICK_DIV (4)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .enable   (enable),
      .reconf   (reconf),
      .time_in  (time_in),
      .timeout  (timeout),
      .sec_tens (sec_tens),
      .sec_ones (sec_ones),
      .running  (running)
   );

   always #5 CLK = ~CLK;

   // Monitor: compare DUT outputs against every queued expectation.
   always @(negedge CLK) begin
      while (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if ((sec_tens !== e.tens) || (sec_ones !== e.ones) ||
             (timeout !== e.to) || (running !== e.run)) begin
            errors++;
            $display("FAIL %s: got tens=%0d ones=%0d timeout=%0b running=%0b, want tens=%0d ones=%0d timeout=%0b running=%0b",
                     e.name, sec_tens, sec_ones, timeout, running,
                     e.tens, e.ones, e.to, e.run);
         end
      end
   end

   task automatic push_exp(input string n, input logic [3:0] t, input logic [3:0] o,
                           input logic to, input logic run);
      exp_t x;
      x.name = n;
      x.tens = t;
      x.ones = o;
      x.to   = to;
      x.run  = run;
      q.push_back(x);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   initial begin
      push_exp("reset", 4'd0, 4'd0, 1'b0, 1'b0);
      cyc(2);
      RST = 1'b1;

      // Load test: 03 counting down with a tick every 4 cycles.
      reconf = 1'b1; time_in = 8'h03;
      cyc(1); push_exp("load03", 4'd0, 4'd3, 1'b0, 1'b0);
      reconf = 1'b0; enable = 1'b1;
      cyc(1); push_exp("run03", 4'd0, 4'd3, 1'b0, 1'b1);
      cyc(3); push_exp("pre_tick03", 4'd0, 4'd3, 1'b0, 1'b1);
      cyc(1); push_exp("tick02", 4'd0, 4'd2, 1'b0, 1'b1);
      cyc(4); push_exp("tick01", 4'd0, 4'd1, 1'b0, 1'b1);
      cyc(4); push_exp("tick00_timeout", 4'd0, 4'd0, 1'b1, 1'b0);
      cyc(5); push_exp("expired_hold", 4'd0, 4'd0, 1'b1, 1'b0);

      // Borrow test: 10 -> 09, then nine more ticks to expiry.
      reconf = 1'b1; time_in = 8'h10;
      cyc(1); push_exp("load10_reconf_wins", 4'd1, 4'd0, 1'b0, 1'b0);
      reconf = 1'b0;
      cyc(1);
      cyc(4); push_exp("borrow09", 4'd0, 4'd9, 1'b0, 1'b1);
      cyc(32); push_exp("borrow01", 4'd0, 4'd1, 1'b0, 1'b1);
      cyc(4); push_exp("borrow_expire", 4'd0, 4'd0, 1'b1, 1'b0);

      // Pause test: phase preserved across a 10-cycle enable drop.
      reconf = 1'b1; time_in = 8'h05;
      cyc(1); push_exp("load05", 4'd0, 4'd5, 1'b0, 1'b0);
      reconf = 1'b0;
      cyc(1);
      cyc(2);
      enable = 1'b0;
      cyc(10); push_exp("paused", 4'd0, 4'd5, 1'b0, 1'b0);
      enable = 1'b1;
      cyc(1); push_exp("resume", 4'd0, 4'd5, 1'b0, 1'b1);
      cyc(1); push_exp("resume_tick04", 4'd0, 4'd4, 1'b0, 1'b1);

      // Clamp and zero-load tests.
      reconf = 1'b1; time_in = 8'hAF;
      cyc(1); push_exp("clamp99", 4'd9, 4'd9, 1'b0, 1'b0);
      time_in = 8'h00;
      cyc(1); push_exp("load00", 4'd0, 4'd0, 1'b0, 1'b0);
      reconf = 1'b0;
      cyc(1); push_exp("run00", 4'd0, 4'd0, 1'b0, 1'b1);
      cyc(1); push_exp("zero_expire", 4'd0, 4'd0, 1'b1, 1'b0);

      // Priority tests: reconf clears timeout, then reconf on a tick edge.
      reconf = 1'b1; time_in = 8'h07;
      cyc(1); push_exp("expired_reconf", 4'd0, 4'd7, 1'b0, 1'b0);
      reconf = 1'b0;
      cyc(1);
      cyc(3); push_exp("pre_tick07", 4'd0, 4'd7, 1'b0, 1'b1);
      reconf = 1'b1; time_in = 8'h42;
      cyc(1); push_exp("tick_vs_load", 4'd4, 4'd2, 1'b0, 1'b0);
      reconf = 1'b0;
      cyc(1);
      cyc(4); push_exp("fresh_phase41", 4'd4, 4'd1, 1'b0, 1'b1);

      // Reset test: asynchronous assertion between edges, then idle.
      cyc(2);
      #2;
      RST = 1'b0;
      push_exp("async_reset", 4'd0, 4'd0, 1'b0, 1'b0);
      cyc(1);
      RST = 1'b1;
      cyc(10); push_exp("idle_after_reset", 4'd0, 4'd0, 1'b0, 1'b0);

      @(negedge CLK);
      #1;
      for (int i = 0; i < 10 && q.size() > 0; i++) begin
         @(negedge CLK);
         #1;
      end
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expectations, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/game_timer.md
GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 TICK_DIV, 50000000, CLK cycles per one-second tick; legal range 2 to 2^26.
REQ-002 CLK  input  1  system clock; all state changes on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-low.
REQ-004 enable  input  1  count-down permission from the access FSM; high = play in progress.
REQ-005 reconf  input  1  reload request from the access FSM; high = load time_in.
REQ-006 time_in  input  8  game duration in seconds, BCD: [7:4] tens, [3:0] ones.
REQ-007 timeout  output  1  registered level; high = game time expired; feeds access FSM timeout.
REQ-008 sec_tens  output  4  remaining-seconds tens digit, BCD, for the display.
REQ-009 sec_ones  output  4  remaining-seconds ones digit, BCD, for the display.
REQ-010 running  output  1  high while state is RUN and enable is high.

Function
REQ-011 States: IDLE, LOADED, RUN, EXPIRED; the encoding is stored in a registered state variable.
REQ-012 IDLE: outputs hold; reconf=1 -> load time_in, clear prescaler, go to LOADED next edge.
REQ-013 Load: each time_in digit greater than 9 shall be clamped to 9 before storing.
REQ-014 LOADED: reconf=1 -> reload every cycle; reconf=0 and enable=1 -> RUN next edge.
REQ-015 RUN: prescaler increments each cycle that enable=1; it holds its value while enable=0 (pause, no decrement).
REQ-016 RUN tick: prescaler at TICK_DIV-1 with enable=1 -> prescaler to 0 and count decremented by one BCD second on the same edge.
REQ-017 BCD decrement: ones 0 -> ones 9 and tens-1; the count never goes below 00.
REQ-018 A tick that takes the count from 01 to 00 enters EXPIRED and sets timeout=1 on the same edge.
REQ-019 Entering RUN with a count of 00 enters EXPIRED on the next edge, with no tick wait.
REQ-020 EXPIRED: timeout=1 held, count held at 00, enable ignored.
REQ-021 reconf=1 in EXPIRED or RUN -> clear timeout, load time_in, clear prescaler, go to LOADED next edge.
REQ-022 reconf and enable high together: reconf wins in every state.
REQ-023 Tick and reconf on the same edge: the load wins and no decrement occurs.
REQ-024 All outputs are registered or decoded from registered state only; the combinational path from input to output is zero.

Reset
REQ-025 RST=0 forces state IDLE, prescaler 0, sec_tens 0, sec_ones 0, timeout 0 and running 0, independent of CLK.
REQ-026 Reset mid-RUN discards the remaining time; after release the block stays in IDLE until reconf=1.

Structure
REQ-027 The shared package holds the state encodings (IDLE=2'b00, LOADED=2'b01, RUN=2'b10, EXPIRED=2'b11) and the default TICK_DIV.
REQ-028 The sub-module sec_prescaler holds the TICK_DIV counter, with inputs clear and count_en and a one-cycle tick output.
REQ-029 The top level holds the FSM and the two-digit BCD down-counter.

Verification (TICK_DIV=4 for all scenarios)
REQ-030 Load test: reconf=1 with time_in=8'h03 for 1 cycle, then enable=1 -> tick every 4 cycles; digits go 03, 02, 01, 00; timeout rises on the tick that yields 00.
REQ-031 Borrow test: load 8'h10, run one tick -> sec_tens=0 and sec_ones=9; a further 9 ticks -> EXPIRED.
REQ-032 Pause test: drop enable for 10 cycles mid-count -> digits and prescaler unchanged; the count resumes with the original phase.
REQ-033 Clamp and zero test: load 8'hAF -> digits read 99; load 8'h00 then enable -> timeout=1 one edge after entering RUN.
REQ-034 Priority test: reconf asserted on the tick edge while in RUN -> reload value shown, no decrement; in EXPIRED, reconf -> timeout=0 next edge.
REQ-035 Reset test: assert RST asynchronously between clock edges mid-RUN -> all outputs 0 immediately; after release, enable alone does not start counting.
